pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-field stage registers between ID/EX/MEM/WB.
- Carries an opaque payload of DATA_W bits with valid/ready handshake on both sides.
- Adds a 2-entry skid buffer, so in_ready is registered and the stage breaks the ready timing path.
- Synchronous flush inserts a bubble of NOP_VALUE; saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_cnt.sv | 25 ++
 rtl/pipe_stage_buf.sv | 129 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for pipeline stage registers: state codes and the default NOP word.
package pipe_pkg;

   // State codes double as the entry count, so occupancy is the state itself.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // addi x0,x0,0 -- bubble value for stages carrying instruction words.
   localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_ONE = W'(1);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register; PIPE_STAGE_SKID_EN adds a skid entry so
// in_ready is decoded from state only, otherwise a single entry with pass-through ready.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] NOP_VALUE   = '0,
   parameter int                STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   input  logic                   stat_clr
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic              load_main;
   logic              in_fire;
   logic              out_fire;
`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] skid_q;
   logic              load_skid;
`endif

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign out_data = main_q;

   // NOTE: payload registers are reset too, so out_data is NOP_VALUE rather than X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_EMPTY;
         main_q <= NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
         skid_q <= NOP_VALUE;
`endif
      end else begin
         state <= state_nxt;
         if (flush) begin
            main_q <= NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= NOP_VALUE;
`endif
         end else begin
            if (load_main) main_q <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            if (load_skid) skid_q <= in_data;
`endif
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      main_d    = in_data;
`ifdef PIPE_STAGE_SKID_EN
      load_skid = 1'b0;
`endif
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_ONE;
                  load_main = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_fire) begin
                  // Downstream stalled: the younger payload parks in the skid entry.
                  state_nxt = ST_FULL;
                  load_skid = 1'b1;
`endif
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
               if (out_fire) begin
                  state_nxt = ST_ONE;
                  load_main = 1'b1;
                  main_d    = skid_q;
               end
            end
`endif
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid = (state != ST_EMPTY);
      occupancy = state;
`ifdef PIPE_STAGE_SKID_EN
      in_ready  = (state != ST_FULL);
`else
      in_ready  = (state == ST_EMPTY) || out_ready;
`endif
   end

   pipe_sat_cnt #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (out_valid && !out_ready),
      .clr (stat_clr),
      .cnt (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [3:0]  stall_cnt;
   logic        stat_clr;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb[$];

   pipe_stage_buf #(
      .DATA_W      (32),
      .NOP_VALUE   (PIPE_NOP),
      .STALL_CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .stat_clr  (stat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Monitor: every output handshake must match the oldest accepted payload.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %h required no output", out_data);
         end else begin
            check("out_data", out_data, sb.pop_front());
         end
      end
   end

   // One clock of stimulus; exp_rdy is the hand-derived in_ready for this cycle.
   task automatic cyc(input logic v, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic clr, input logic exp_rdy);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      stat_clr  = clr;
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (v && exp_rdy && !fl) sb.push_back(d);
      @(posedge clk);
      #2;
      if (fl) sb.delete();
   endtask

   task automatic chk_state(input string tag, input int occ, input int stall);
      check({tag, "_occ"}, 32'(occupancy), 32'(occ));
      check({tag, "_vld"}, 32'(out_valid), 32'(occ != 0));
      check({tag, "_stall"}, 32'(stall_cnt), 32'(stall));
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; stat_clr = 1'b0;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_vld", 32'(out_valid), 32'd0);
         check("rst_data", out_data, PIPE_NOP);
         check("rst_rdy", 32'(in_ready), 32'd1);
         check("rst_occ", 32'(occupancy), 32'd0);
         check("rst_stall", 32'(stall_cnt), 32'd0);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid = 1'b0;

      // Streaming 1..8; first payload visible one cycle after its in_fire.
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
         if (i == 1) check("latency_data", out_data, 32'd1);
         chk_state("stream", 1, 0);
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("drain", 0, 0);

      // Backpressure A, B, C.
`ifdef PIPE_STAGE_SKID_EN
      cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("bp1", 1, 0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("bp2", 2, 1);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0); chk_state("bp3", 2, 2);
      cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0); chk_state("bp4", 1, 2);
      cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1); chk_state("bp5", 1, 2);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1); chk_state("bp6", 0, 2);
`else
      cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("bp1", 1, 0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0); chk_state("bp2", 1, 1);
      cyc(1'b1, 32'hB, 1'b1, 1'b0, 1'b0, 1'b1); chk_state("bp3", 1, 1);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0); chk_state("bp4", 1, 2);
      cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1); chk_state("bp5", 1, 2);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1); chk_state("bp6", 0, 2);
`endif
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_state("clr1", 0, 0);

      // Flush with a coincident offered payload X.
`ifdef PIPE_STAGE_SKID_EN
      cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("fl1", 1, 0);
      cyc(1'b1, 32'hE, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("fl2", 2, 1);
      cyc(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_state("flush", 0, 2);
`else
      cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1); chk_state("fl1", 1, 0);
      cyc(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_state("flush", 0, 1);
`endif
      check("flush_data", out_data, PIPE_NOP);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
         check("post_flush_vld", 32'(out_valid), 32'd0);
      end

      // Saturation of the 4-bit stall counter.
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_state("clr2", 0, 0);
      cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, SKID);
         check("sat_stall", 32'(stall_cnt), (k < 15) ? 32'(k) : 32'd15);
      end
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, SKID);
      chk_state("sat_clr", 1, 0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("sat_drain", 0, 0);

      // Asynchronous reset while holding a payload.
      cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_state("pre_rst", 1, 0);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_vld", 32'(out_valid), 32'd0);
      check("mid_rst_occ", 32'(occupancy), 32'd0);
      check("mid_rst_data", out_data, PIPE_NOP);
      check("mid_rst_rdy", 32'(in_ready), 32'd1);
      sb.delete();
      @(posedge clk);
      #2;
      rst = 1'b1;
      cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
      check("post_rst_data", out_data, 32'h1234_5678);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_state("end", 0, 0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
